rr_arbiter_wrr: RTL
===================

// Module: rr_arbiter_wrr
//
// PURPOSE
//  Weighted round-robin arbiter with registered one-hot grant and burst hold.
//  Successor to the basic round-robin arbiter. Adds per-port weights, an ack
//  handshake that consumes credits, and a grant lock while a burst is in progress.
//  Sits in front of a shared resource (bus or memory port) that is accessed by
//  NUM_PORTS requesters.
//
// PARAMETERS
//  NUM_PORTS  4  number of requesters; must be >= 2
//  WEIGHT_W   4  width of each per-port weight and of the credit counter
//  ID_W       $clog2(NUM_PORTS)  width of gnt_id_o (derived; do not override)
//
// PORTS
//  clk        in   1                    single clock, rising edge
//  reset      in   1                    synchronous, active-high reset
//  req_i      in   NUM_PORTS            level request per port; held until served
//  weight_i   in   NUM_PORTS*WEIGHT_W   port p weight = weight_i[p*WEIGHT_W +: WEIGHT_W]
//  ack_i      in   1                    resource accepted one beat from the current owner
//  gnt_o      out  NUM_PORTS            registered one-hot grant; all zero when idle
//  gnt_vld_o  out  1                    equals |gnt_o (registered)
//  gnt_id_o   out  ID_W                 binary index of the owner; 0 when idle
//
// BEHAVIOUR
//  - Reset (sync): gnt_o=0, gnt_vld_o=0, gnt_id_o=0, ptr=0, credit=0, state=IDLE.
//    Reset takes effect on any cycle, including mid-burst. The first grant after
//    reset can appear no earlier than 2 edges after reset deasserts.
//  - Internal state: ptr (ID_W), owner (ID_W), credit (WEIGHT_W), FSM {IDLE, GRANT}.
//  - Arbitration function: scan ports in the order ptr, ptr+1, ..., ptr+N-1 (mod N).
//    The first asserted req_i bit wins. The function is purely combinational and
//    uses the current req_i.
//  - IDLE: when any req_i is set at an edge, the winner becomes owner.
//    credit <= max(weight[winner],1) (weight 0 is treated as 1). State -> GRANT.
//    gnt_o, gnt_vld_o and gnt_id_o update at that same edge, so latency is one cycle
//    from req to grant. If no req_i is set, stay in IDLE with all outputs 0.
//  - GRANT: gnt_o holds onehot(owner). At each edge:
//      * req_i[owner]=0 -> release. Any ack_i on that cycle is ignored (no credit used).
//      * req_i[owner]=1 & ack_i=1 & credit==1 -> consume the credit, then release.
//      * req_i[owner]=1 & ack_i=1 & credit>1  -> credit <= credit-1; hold the grant.
//      * req_i[owner]=1 & ack_i=0             -> hold; no change.
//  - Release at an edge:
//      * ptr <= owner+1 (mod N; wraps from N-1 to 0).
//      * Arbitrate in the same cycle, using the new ptr and the current req_i.
//      * If there is a winner, load the new owner and credit, stay in GRANT, and drive
//        the new gnt_o from the next cycle. There is no bubble.
//      * The old owner may win again only if it is the sole requester.
//      * With no winner: state -> IDLE; gnt_o=0 next cycle.
//  - Weights are sampled only when an owner is loaded. Changes to weight_i during a
//    burst have no effect until the next load.
//  - ack_i while in IDLE or while gnt_o=0 is ignored.
//  - Requests from non-owners never preempt the current owner.
//  - Invariants: gnt_o is zero or one-hot. gnt_o[owner]=1 implies req_i[owner] was 1
//    at the load edge. Credit never underflows. No port waits longer than
//    (N-1)*max(weight) acked beats once it requests, provided every owner either
//    keeps requesting or drops.
//
// TESTING
//  1. N=4, all weights=1, req_i=4'b1111 held, ack_i=1 every cycle -> gnt_id_o
//     sequence 0,1,2,3,0,1 on consecutive cycles, with no idle cycle between grants.
//  2. weights {p0=3,p1=1,p2=1,p3=1}, all requesting, ack_i=1 -> gnt_o holds 4'b0001
//     for 3 cycles, then 4'b0010, 4'b0100, 4'b1000, 4'b0001.
//  3. p0 granted with weight 4; drop req_i[0] after 1 ack while req_i[2]=1 -> the
//     next cycle gnt_o=4'b0100 and ptr=1; the ack on the drop cycle is not counted.
//  4. Only p3 requests, weight 0, ack_i=1 -> grant p3, release after 1 ack, re-grant
//     p3 on the next cycle (ptr wraps to 0); gnt_o stays 4'b1000 with no bubble.
//  5. Ack with no grant: ack_i=1 while idle -> no state change. Hold ack_i=0 during a
//     grant for 10 cycles -> grant held and credit unchanged.
//  6. Assert reset for 1 cycle mid-burst (owner p2, credit 2) -> the next cycle
//     gnt_o=0, gnt_id_o=0. With req_i=4'b0100 still high, p2 is re-granted with full
//     weight once the FSM has returned to IDLE (search starts from ptr=0).

Source files
------------

// File: rtl/rr_arbiter_wrr.sv
// Weighted round-robin arbiter with a registered one-hot grant.
// Each owner keeps the grant for up to weight[owner] acked beats (weight 0
// counts as 1). Ownership passes on without a bubble, and the search
// always starts just past the previous owner.
module rr_arbiter_wrr #(
  parameter int NUM_PORTS = 4,
  parameter int WEIGHT_W  = 4,
  parameter int ID_W      = $clog2(NUM_PORTS)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_PORTS-1:0]          req_i,
  input  logic [NUM_PORTS*WEIGHT_W-1:0] weight_i,
  input  logic                          ack_i,
  output logic [NUM_PORTS-1:0]          gnt_o,
  output logic                          gnt_vld_o,
  output logic [ID_W-1:0]               gnt_id_o
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t                state, state_n;
  logic [ID_W-1:0]       ptr, ptr_n;
  logic [ID_W-1:0]       owner, owner_n;
  logic [WEIGHT_W-1:0]   credit, credit_n;
  logic                  armed;

  logic [ID_W-1:0]       search_ptr;
  logic                  win_vld;
  logic [ID_W-1:0]       win_id;
  logic [WEIGHT_W-1:0]   win_weight;
  logic                  release_now;
  logic                  load;

  // Modulo-N increment of a port index. Plain addition is not enough when
  // NUM_PORTS is not a power of two.
  function automatic logic [ID_W-1:0] next_idx(input logic [ID_W-1:0] idx);
    if (idx == ID_W'(NUM_PORTS - 1))
      return '0;
    else
      return idx + ID_W'(1);
  endfunction

  // The owner gives up the grant when it drops its request, or when it
  // spends its last credit. An ack that arrives with a dropped request is
  // not counted.
  always_comb begin
    release_now = 1'b0;
    if (state == GRANT)
      release_now = !req_i[owner] || (ack_i && (credit == WEIGHT_W'(1)));
  end

  // The search starts at ptr when idle. On a release it starts just past
  // the outgoing owner, which is the pointer value being written this cycle.
  always_comb begin
    search_ptr = ptr;
    if (release_now)
      search_ptr = next_idx(owner);
  end

  // The first asserted request wins, scanning circularly from search_ptr.
  always_comb begin
    win_vld = 1'b0;
    win_id  = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      int              idx;
      logic [ID_W-1:0] idx_w;
      idx = int'(search_ptr) + i;
      if (idx >= NUM_PORTS)
        idx = idx - NUM_PORTS;
      idx_w = ID_W'(idx);
      if (!win_vld && req_i[idx_w]) begin
        win_vld = 1'b1;
        win_id  = idx_w;
      end
    end
  end

  // Weight of the candidate winner. It is only used at a load, so weight
  // changes during a burst have no effect until the next load.
  always_comb begin
    win_weight = weight_i[win_id*WEIGHT_W +: WEIGHT_W];
  end

  // Next-state logic. Loads happen from IDLE (once armed after reset) or on
  // a release in GRANT. Either way the new owner and its credit are loaded.
  always_comb begin
    state_n  = state;
    ptr_n    = ptr;
    owner_n  = owner;
    credit_n = credit;
    load     = 1'b0;
    case (state)
      IDLE: begin
        if (armed && win_vld)
          load = 1'b1;
      end
      GRANT: begin
        if (release_now) begin
          ptr_n = next_idx(owner);
          if (win_vld)
            load = 1'b1;
          else
            state_n = IDLE;
        end else if (ack_i) begin
          credit_n = credit - WEIGHT_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase
    if (load) begin
      state_n  = GRANT;
      owner_n  = win_id;
      credit_n = (win_weight == '0) ? WEIGHT_W'(1) : win_weight;
    end
  end

  // State and grant registers. A grant after reset needs one extra edge to
  // arm, so it cannot appear on the first edge after reset is released.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      ptr       <= '0;
      owner     <= '0;
      credit    <= '0;
      armed     <= 1'b0;
      gnt_o     <= '0;
      gnt_vld_o <= 1'b0;
      gnt_id_o  <= '0;
    end else begin
      state  <= state_n;
      ptr    <= ptr_n;
      owner  <= owner_n;
      credit <= credit_n;
      armed  <= 1'b1;
      if (state_n == GRANT) begin
        gnt_o     <= NUM_PORTS'(1) << owner_n;
        gnt_vld_o <= 1'b1;
        gnt_id_o  <= owner_n;
      end else begin
        gnt_o     <= '0;
        gnt_vld_o <= 1'b0;
        gnt_id_o  <= '0;
      end
    end
  end

endmodule
